// File: rtl/clint_pkg.sv
// Shared constants for the core-local interrupter: register offsets, interrupt
// cause codes, bus FSM state type and the byte-lane write-merge helper.
package clint_pkg;

    localparam logic [15:0] clint_msip_off     = 16'h0000;
    localparam logic [15:0] clint_mtimecmp_off = 16'h4000;
    localparam logic [15:0] clint_mtime_off    = 16'hBFF8;

    // Cause codes, also the mip bit positions used by the CSR unit.
    localparam logic [3:0] interrupt_mach_soft  = 4'd3;
    localparam logic [3:0] interrupt_mach_timer = 4'd7;

    typedef enum logic {
        bus_idle = 1'b0,
        bus_resp = 1'b1
    } bus_state_t;

    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] merged;
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = strb[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/clint.sv
// Core-local interrupter: owns msip, mtime and mtimecmp behind a one-cycle-latency
// memory-mapped responder and raises the machine software/timer interrupts.
module clint
    import clint_pkg::*;
#(
    parameter int unsigned RTC_DIV = 10
) (
    input  logic        reset,
    input  logic        clock,
    input  logic        clint_valid,
    input  logic        clint_instr,
    input  logic [31:0] clint_addr,
    input  logic [3:0]  clint_wstrb,
    input  logic [31:0] clint_wdata,
    output logic [31:0] clint_rdata,
    output logic        clint_ready,
    output logic        clint_msip,
    output logic        clint_mtip,
    output logic [63:0] clint_mtime
);

    localparam int unsigned PW = (RTC_DIV > 1) ? $clog2(RTC_DIV) : 1;
    localparam logic [PW-1:0] presc_max = PW'(RTC_DIV - 1);

    logic [PW-1:0] presc;
    logic [63:0]   mtime;
    logic [63:0]   mtimecmp;
    logic          msip;
    bus_state_t    bus_state;

    logic [15:0] offset;
    logic        is_write;
    logic        sel_msip, sel_cmp_lo, sel_cmp_hi, sel_time_lo, sel_time_hi;
    logic        tick;
    logic [31:0] read_val;
    logic        unused_addr;

    // Valid/ready: a request is accepted in any cycle clint_valid is high; exactly
    // one cycle later clint_ready pulses with clint_rdata. There is no backpressure
    // and fetches (clint_instr) never write.
    assign offset      = clint_addr[15:0];
    assign unused_addr = ^clint_addr[31:16];
    assign is_write    = clint_valid && !clint_instr && (clint_wstrb != 4'h0);

    assign sel_msip    = (offset == clint_msip_off);
    assign sel_cmp_lo  = (offset == clint_mtimecmp_off);
    assign sel_cmp_hi  = (offset == clint_mtimecmp_off + 16'h0004);
    assign sel_time_lo = (offset == clint_mtime_off);
    assign sel_time_hi = (offset == clint_mtime_off + 16'h0004);

    assign tick = (presc == presc_max);

    always_comb begin
        read_val = 32'h0;
        if (sel_msip)    read_val = {31'h0, msip};
        if (sel_cmp_lo)  read_val = mtimecmp[31:0];
        if (sel_cmp_hi)  read_val = mtimecmp[63:32];
        if (sel_time_lo) read_val = mtime[31:0];
        if (sel_time_hi) read_val = mtime[63:32];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            presc       <= '0;
            mtime       <= 64'h0;
            mtimecmp    <= 64'hFFFF_FFFF_FFFF_FFFF;
            msip        <= 1'b0;
            clint_mtip  <= 1'b0;
            clint_rdata <= 32'h0;
            bus_state   <= bus_idle;
        end else begin
            if (is_write && sel_msip && clint_wstrb[0]) begin
                msip <= clint_wdata[0];
            end
            if (is_write && sel_cmp_lo) begin
                mtimecmp[31:0] <= apply_wstrb(mtimecmp[31:0], clint_wdata, clint_wstrb);
            end
            if (is_write && sel_cmp_hi) begin
                mtimecmp[63:32] <= apply_wstrb(mtimecmp[63:32], clint_wdata, clint_wstrb);
            end

            // A software write to mtime wins over a coincident tick and restarts the prescaler.
            if (is_write && (sel_time_lo || sel_time_hi)) begin
                presc <= '0;
                if (sel_time_lo) begin
                    mtime[31:0] <= apply_wstrb(mtime[31:0], clint_wdata, clint_wstrb);
                end else begin
                    mtime[63:32] <= apply_wstrb(mtime[63:32], clint_wdata, clint_wstrb);
                end
            end else if (tick) begin
                presc <= '0;
                mtime <= mtime + 64'd1;
            end else begin
                presc <= presc + PW'(1);
            end

            clint_mtip <= (mtime >= mtimecmp);

            if (clint_valid) begin
                bus_state   <= bus_resp;
                clint_rdata <= read_val;
            end else begin
                bus_state   <= bus_idle;
                clint_rdata <= 32'h0;
            end
        end
    end

    assign clint_ready = (bus_state == bus_resp);
    assign clint_msip  = msip;
    assign clint_mtime = mtime;

endmodule

// File: tb/tb_clint.sv
// Directed bench for clint with RTC_DIV=4: register map, byte masking, timer
// tick/compare timing, wrap-around, back-to-back reads and reset mid-request.
module tb_clint;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        valid = 1'b0;
    logic        instr = 1'b0;
    logic [31:0] addr  = 32'h0;
    logic [3:0]  wstrb = 4'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] clint_rdata;
    logic        clint_ready;
    logic        clint_msip;
    logic        clint_mtip;
    logic [63:0] clint_mtime;

    int checks = 0;
    int errors = 0;

    logic [31:0] rd;
    logic        rdy;
    logic [31:0] exp_q[$];

    clint #(.RTC_DIV(4)) dut (
        .reset       (reset),
        .clock       (clock),
        .clint_valid (valid),
        .clint_instr (instr),
        .clint_addr  (addr),
        .clint_wstrb (wstrb),
        .clint_wdata (wdata),
        .clint_rdata (clint_rdata),
        .clint_ready (clint_ready),
        .clint_msip  (clint_msip),
        .clint_mtip  (clint_mtip),
        .clint_mtime (clint_mtime)
    );

    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // One request in cycle N; returns what the bus shows in cycle N+1.
    task automatic bus_req(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                           input logic fetch, output logic [31:0] r, output logic ok);
        @(negedge clock);
        valid = 1'b1;
        instr = fetch;
        addr  = a;
        wstrb = s;
        wdata = d;
        @(posedge clock);
        #1;
        ok    = clint_ready;
        r     = clint_rdata;
        valid = 1'b0;
        instr = 1'b0;
        wstrb = 4'h0;
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] addrs [3];
        logic [31:0] exps  [3];
        addrs = '{32'h4000, 32'h4004, 32'h0000};
        exps  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
        reset = 1'b0;
        repeat (2) @(negedge clock);
        checks++; if (clint_mtip !== 1'b0) begin errors++; $display("FAIL reset_mtip got %b exp 0", clint_mtip); end
        checks++; if (clint_msip !== 1'b0) begin errors++; $display("FAIL reset_msip got %b exp 0", clint_msip); end
        checks++; if (clint_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", clint_ready); end
        checks++; if (clint_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", clint_rdata); end
        checks++; if (clint_mtime !== 64'h0) begin errors++; $display("FAIL reset_mtime got %h exp 0", clint_mtime); end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus_req(addrs[i], 4'h0, 32'h0, 1'b0, rd, rdy);
            checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL reset_read_ready[%0d] got %b exp 1", i, rdy); end
            checks++; if (rd !== exps[i]) begin errors++; $display("FAIL reset_read[%0d] got %h exp %h", i, rd, exps[i]); end
        end
        @(posedge clock);
        #1;
        checks++; if (clint_ready !== 1'b0) begin errors++; $display("FAIL ready_one_cycle got %b exp 0", clint_ready); end
        checks++; if (clint_mtip !== 1'b0) begin errors++; $display("FAIL reset_mtip_after got %b exp 0", clint_mtip); end
    endtask

    task automatic test_msip();
        bus_req(32'h0000, 4'hF, 32'hFFFF_FFFF, 1'b0, rd, rdy);
        checks++; if (clint_msip !== 1'b1) begin errors++; $display("FAIL msip_set got %b exp 1", clint_msip); end
        bus_req(32'h0000, 4'h0, 32'h0, 1'b0, rd, rdy);
        checks++; if (rd !== 32'h0000_0001) begin errors++; $display("FAIL msip_read got %h exp 00000001", rd); end
        bus_req(32'h0000, 4'hE, 32'h0, 1'b0, rd, rdy);
        checks++; if (clint_msip !== 1'b1) begin errors++; $display("FAIL msip_no_byte0 got %b exp 1", clint_msip); end
        bus_req(32'h0000, 4'hF, 32'h0, 1'b1, rd, rdy);
        checks++; if (clint_msip !== 1'b1) begin errors++; $display("FAIL msip_fetch_no_write got %b exp 1", clint_msip); end
        checks++; if (rd !== 32'h0000_0001) begin errors++; $display("FAIL msip_fetch_read got %h exp 00000001", rd); end
        bus_req(32'h0000, 4'h1, 32'h0, 1'b0, rd, rdy);
        checks++; if (clint_msip !== 1'b0) begin errors++; $display("FAIL msip_clear got %b exp 0", clint_msip); end
    endtask

    task automatic test_byte_mask();
        apply_reset();
        bus_req(32'h4000, 4'h2, 32'h1234_5678, 1'b0, rd, rdy);
        bus_req(32'h4000, 4'h0, 32'h0, 1'b0, rd, rdy);
        checks++; if (rd !== 32'hFFFF_56FF) begin errors++; $display("FAIL byte_mask_lo got %h exp ffff56ff", rd); end
        bus_req(32'h4004, 4'h0, 32'h0, 1'b0, rd, rdy);
        checks++; if (rd !== 32'hFFFF_FFFF) begin errors++; $display("FAIL byte_mask_hi got %h exp ffffffff", rd); end
    endtask

    task automatic test_unmapped();
        bus_req(32'h1000, 4'hF, 32'hDEAD_BEEF, 1'b0, rd, rdy);
        bus_req(32'h1000, 4'h0, 32'h0, 1'b0, rd, rdy);
        checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL unmapped_ready got %b exp 1", rdy); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL unmapped_read got %h exp 0", rd); end
        bus_req(32'hFFFF_4000, 4'h0, 32'h0, 1'b0, rd, rdy);
        checks++; if (rd !== 32'hFFFF_56FF) begin errors++; $display("FAIL upper_addr_ignored got %h exp ffff56ff", rd); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [5];
        logic [31:0] exps  [5];
        logic [31:0] e;
        addrs = '{32'h4000, 32'h4004, 32'h0000, 32'h1000, 32'h4004};
        exps  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'hFFFF_FFFF};
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            valid = 1'b1;
            addr  = addrs[i];
            exp_q.push_back(exps[i]);
            @(posedge clock);
            #1;
            e = exp_q.pop_front();
            checks++; if (clint_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d] got %b exp 1", i, clint_ready); end
            checks++; if (clint_rdata !== e) begin errors++; $display("FAIL b2b_rdata[%0d] got %h exp %h", i, clint_rdata, e); end
        end
        valid = 1'b0;
        @(posedge clock);
        #1;
        checks++; if (clint_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_drop got %b exp 0", clint_ready); end
    endtask

    task automatic test_timer();
        int cyc;
        int last_change;
        int first10;
        int first_mtip;
        logic [63:0] prev;
        apply_reset();
        bus_req(32'h4004, 4'hF, 32'h0, 1'b0, rd, rdy);
        bus_req(32'h4000, 4'hF, 32'd10, 1'b0, rd, rdy);
        cyc = 0;
        last_change = -1;
        first10 = -1;
        first_mtip = -1;
        prev = clint_mtime;
        while (clint_mtime < 64'd13 && cyc < 100) begin
            @(posedge clock);
            #1;
            cyc++;
            checks++;
            if (clint_mtip !== (prev >= 64'd10)) begin
                errors++;
                $display("FAIL timer_mtip cyc %0d got %b exp %b (mtime was %0d)", cyc, clint_mtip, prev >= 64'd10, prev);
            end
            if (clint_mtime !== prev) begin
                checks++;
                if (clint_mtime !== prev + 64'd1) begin
                    errors++; $display("FAIL timer_step got %0d exp %0d", clint_mtime, prev + 64'd1);
                end
                if (last_change >= 0) begin
                    checks++;
                    if (cyc - last_change != 4) begin
                        errors++; $display("FAIL timer_period got %0d exp 4", cyc - last_change);
                    end
                end
                last_change = cyc;
                if (clint_mtime == 64'd10) first10 = cyc;
            end
            if (clint_mtip === 1'b1 && first_mtip < 0) first_mtip = cyc;
            prev = clint_mtime;
        end
        checks++; if (clint_mtime !== 64'd13) begin errors++; $display("FAIL timer_reach got %0d exp 13", clint_mtime); end
        checks++; if (first_mtip - first10 != 1) begin errors++; $display("FAIL timer_mtip_latency got %0d exp 1", first_mtip - first10); end
    endtask

    task automatic test_mtip_clear();
        bus_req(32'h4000, 4'hF, 32'd1000, 1'b0, rd, rdy);
        checks++; if (clint_mtip !== 1'b1) begin errors++; $display("FAIL mtip_clear_n1 got %b exp 1", clint_mtip); end
        @(posedge clock);
        #1;
        checks++; if (clint_mtip !== 1'b0) begin errors++; $display("FAIL mtip_clear_n2 got %b exp 0", clint_mtip); end
    endtask

    task automatic test_mtime_wrap();
        bus_req(32'hBFF8, 4'hF, 32'hFFFF_FFFF, 1'b0, rd, rdy);
        bus_req(32'hBFFC, 4'hF, 32'h0, 1'b0, rd, rdy);
        repeat (3) @(posedge clock);
        #1;
        checks++; if (clint_mtime !== 64'h0000_0000_FFFF_FFFF) begin errors++; $display("FAIL wrap_loaded got %h exp 00000000ffffffff", clint_mtime); end
        bus_req(32'hBFF8, 4'h0, 32'h0, 1'b0, rd, rdy);
        checks++; if (rd !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_pretick_read got %h exp ffffffff", rd); end
        checks++; if (clint_mtime !== 64'h0000_0001_0000_0000) begin errors++; $display("FAIL wrap_carry got %h exp 0000000100000000", clint_mtime); end
        bus_req(32'hBFFC, 4'h0, 32'h0, 1'b0, rd, rdy);
        checks++; if (rd !== 32'h0000_0001) begin errors++; $display("FAIL wrap_read_hi got %h exp 00000001", rd); end
        bus_req(32'hBFF8, 4'h0, 32'h0, 1'b0, rd, rdy);
        checks++; if (rd !== 32'h0000_0000) begin errors++; $display("FAIL wrap_read_lo got %h exp 00000000", rd); end
    endtask

    task automatic test_reset_mid_request();
        @(negedge clock);
        valid = 1'b1;
        addr  = 32'h4000;
        @(posedge clock);
        #1;
        valid = 1'b0;
        checks++; if (clint_ready !== 1'b1) begin errors++; $display("FAIL midreset_ready_before got %b exp 1", clint_ready); end
        #1;
        reset = 1'b0;
        #1;
        checks++; if (clint_ready !== 1'b0) begin errors++; $display("FAIL midreset_async_drop got %b exp 0", clint_ready); end
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            checks++; if (clint_ready !== 1'b0) begin errors++; $display("FAIL midreset_no_resp[%0d] got %b exp 0", i, clint_ready); end
        end
    endtask

    initial begin
        test_reset();
        test_msip();
        test_byte_mask();
        test_unmapped();
        test_back_to_back();
        test_timer();
        test_mtip_clear();
        test_mtime_wrap();
        test_reset_mid_request();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
